// File: rtl/xgriscv_mdu_pkg.sv
// ============================================================================
// xgriscv_mdu_pkg : shared encodings for the RV32M multiply/divide unit
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package xgriscv_mdu_pkg;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_DIV  = 2'd1,
      MDU_FIN  = 2'd2,
      MDU_DONE = 2'd3
   } mdu_state_e;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

endpackage

`default_nettype wire

// File: rtl/xgriscv_mdu_divider.sv
// ============================================================================
// xgriscv_mdu_divider : unsigned restoring divider, one quotient bit per step
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module xgriscv_mdu_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_load,
   input  logic            i_step,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_quotient,
   output logic [XLEN-1:0] o_remainder,
   output logic            o_last
);

   localparam int              CNT_W  = $clog2(XLEN);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(XLEN - 1);

   logic [XLEN-1:0]  r_div;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [CNT_W-1:0] r_cnt;

   logic [XLEN:0]    w_shift;
   logic [XLEN:0]    w_diff;
   logic             w_ge;

   // The dividend shifts out of r_quo MSB-first while quotient bits shift in.
   assign w_shift = {r_rem, r_quo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_div};
   assign w_ge    = ~w_diff[XLEN];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_div <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_div <= i_divisor;
         r_rem <= '0;
         r_quo <= i_dividend;
         r_cnt <= '0;
      end else if (i_step) begin
         r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
         r_quo <= {r_quo[XLEN-2:0], w_ge};
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_quotient  = r_quo;
   assign o_remainder = r_rem;
   assign o_last      = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/xgriscv_mdu.sv
// ============================================================================
// xgriscv_mdu : iterative RV32M multiply/divide unit with register write-back
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module xgriscv_mdu
   import xgriscv_mdu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   flush,
   input  logic [2:0]             funct3,
   input  logic [XLEN-1:0]        rs1_data,
   input  logic [XLEN-1:0]        rs2_data,
   input  logic [RFIDX_WIDTH-1:0] rd_idx,
   output logic                   busy,
   output logic                   done,
   output logic [XLEN-1:0]        result,
   output logic [RFIDX_WIDTH-1:0] wb_rd,
   output logic                   wb_en
);

   mdu_state_e             r_state;
   mdu_state_e             w_state_nxt;
   logic [XLEN-1:0]        r_result;
   logic [RFIDX_WIDTH-1:0] r_wb_rd;
   logic [RFIDX_WIDTH-1:0] r_rd;
   logic                   r_is_rem;
   logic                   r_neg_q;
   logic                   r_neg_r;

   logic w_accept, w_is_mul, w_is_div, w_div_signed, w_is_rem;
   logic w_div0, w_ovf, w_fast;
   logic w_a_sx, w_b_sx;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_fast_res, w_fin_res;
   logic [XLEN:0]     w_a33, w_b33;
   logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;
   logic              w_last;

   assign w_accept     = (r_state == MDU_IDLE) && start && !flush;
   assign w_is_mul     = funct3 inside {FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU};
   assign w_is_div     = funct3 inside {FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU};
   assign w_div_signed = funct3 inside {FUNCT3_DIV, FUNCT3_REM};
   assign w_is_rem     = funct3 inside {FUNCT3_REM, FUNCT3_REMU};
   assign w_div0       = (rs2_data == '0);
   assign w_ovf        = w_div_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
   assign w_fast       = w_is_mul || w_div0 || w_ovf;

   // Low product bits are sign-agnostic, so only the high-half ops steer extension.
   assign w_a_sx  = (funct3 inside {FUNCT3_MULH, FUNCT3_MULHSU}) && rs1_data[XLEN-1];
   assign w_b_sx  = (funct3 == FUNCT3_MULH) && rs2_data[XLEN-1];
   assign w_a33   = {w_a_sx, rs1_data};
   assign w_b33   = {w_b_sx, rs2_data};
   assign w_a_ext = {{(XLEN-1){w_a33[XLEN]}}, w_a33};
   assign w_b_ext = {{(XLEN-1){w_b33[XLEN]}}, w_b33};
   assign w_prod  = w_a_ext * w_b_ext;

   assign w_a_mag = (w_div_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
   assign w_b_mag = (w_div_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

   always_comb begin
      w_fast_res = '0;
      if (w_is_mul)
         w_fast_res = (funct3 == FUNCT3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
      else if (w_div0)
         w_fast_res = w_is_rem ? rs1_data : '1;
      else
         w_fast_res = w_is_rem ? '0 : rs1_data;
   end

   xgriscv_mdu_divider #(.XLEN(XLEN)) u_divider (
      .clk         (clk),
      .rstn        (rstn),
      .i_load      (w_accept && w_is_div && !w_fast),
      .i_step      (r_state == MDU_DIV),
      .i_dividend  (w_a_mag),
      .i_divisor   (w_b_mag),
      .o_quotient  (w_quo),
      .o_remainder (w_rem),
      .o_last      (w_last)
   );

   assign w_fin_res = r_is_rem ? (r_neg_r ? -w_rem : w_rem)
                               : (r_neg_q ? -w_quo : w_quo);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MDU_IDLE: if (w_accept) w_state_nxt = w_fast ? MDU_DONE : MDU_DIV;
         MDU_DIV:  if (flush) w_state_nxt = MDU_IDLE;
                   else if (w_last) w_state_nxt = MDU_FIN;
         MDU_FIN:  w_state_nxt = flush ? MDU_IDLE : MDU_DONE;
         default:  w_state_nxt = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= MDU_IDLE;
         r_result <= '0;
         r_wb_rd  <= '0;
         r_rd     <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_rd     <= rd_idx;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_div_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
            r_neg_r  <= w_div_signed && rs1_data[XLEN-1];
            if (w_fast) begin
               r_result <= w_fast_res;
               r_wb_rd  <= rd_idx;
            end
         end
         // Write-back registers only change when an op commits.
         if (r_state == MDU_FIN && !flush) begin
            r_result <= w_fin_res;
            r_wb_rd  <= r_rd;
         end
      end
   end

   assign busy   = (r_state != MDU_IDLE);
   assign done   = (r_state == MDU_DONE);
   assign result = r_result;
   assign wb_rd  = r_wb_rd;
   assign wb_en  = done && (r_wb_rd != '0);

endmodule

`default_nettype wire

// File: tb/tb_xgriscv_mdu.sv
// ============================================================================
// tb_xgriscv_mdu : directed + randomized check of xgriscv_mdu against a model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xgriscv_mdu;

   logic        clk = 1'b0;
   logic        rstn, start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_idx;
   logic        busy, done, wb_en;
   logic [31:0] result;
   logic [4:0]  wb_rd;

   int n_asserts = 0;
   int n_fails   = 0;

   always #5 clk = ~clk;

   xgriscv_mdu #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
      .clk(clk), .rstn(rstn), .start(start), .flush(flush), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_idx(rd_idx),
      .busy(busy), .done(done), .result(result), .wb_rd(wb_rd), .wb_en(wb_en)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Architectural RV32M semantics using plain integer arithmetic.
   function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      p;
      logic [63:0] u;
      int          q;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
         3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
         3'd2: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
         3'd3: begin u = {32'h0, a} * {32'h0, b}; return u[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            q = $signed(a) / $signed(b);
            return q;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            q = $signed(a) % $signed(b);
            return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2] || b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk);
      funct3 = f3; rs1_data = a; rs2_data = b; rd_idx = rd; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic count_dones(input string tag, input int cycles);
      int n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      check({tag, "_no_done"}, 64'(n), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
      logic [31:0] exp;
      int lat = 0;
      bit busy_ok = 1'b1;
      exp = ref_mdu(f3, a, b);
      issue(f3, a, b, rd);
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         if (done) begin lat = i; break; end
      end
      check({tag, "_latency"}, 64'(lat), 64'(ref_lat(f3, a, b)));
      check({tag, "_busy"}, 64'(busy_ok), 64'd1);
      check({tag, "_result"}, 64'(result), 64'(exp));
      check({tag, "_wb_rd"}, 64'(wb_rd), 64'(rd));
      check({tag, "_wb_en"}, 64'(wb_en), 64'(rd != 0));
      @(negedge clk);
      check({tag, "_pulse"}, 64'(done), 64'd0);
      check({tag, "_hold"}, 64'(result), 64'(exp));
   endtask

   initial begin
      int lat;
      rstn = 1'b0; start = 1'b0; flush = 1'b0;
      funct3 = '0; rs1_data = '0; rs2_data = '0; rd_idx = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wb_en", 64'(wb_en), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_wb_rd", 64'(wb_rd), 64'd0);
      rstn = 1'b1;

      run_op("mul", 3'd0, 32'h7, 32'hFFFF_FFFD, 5'd5);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
      run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
      run_op("div", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9);
      run_op("rem", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10);
      run_op("divu", 3'd5, 32'd100, 32'd7, 5'd11);
      run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd12);
      run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd13);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
      run_op("mul_x0", 3'd0, 32'd3, 32'd4, 5'd0);

      // Flush ten cycles into a long divide.
      issue(3'd4, 32'd1000, 32'd7, 5'd4);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      count_dones("flush", 40);
      run_op("post_flush_mul", 3'd0, 32'd12345, 32'd678, 5'd3);

      // Flush and start together: start is dropped.
      @(negedge clk);
      funct3 = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2; rd_idx = 5'd2;
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", 64'(busy), 64'd0);
      count_dones("flush_start", 5);

      // Start pulses while busy and during the done cycle are ignored.
      issue(3'd5, 32'd100, 32'd7, 5'd3);
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 5) begin funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_idx = 5'd1; start = 1'b1; end
         if (i == 6) start = 1'b0;
         if (done) begin lat = i; break; end
      end
      check("busy_start_lat", 64'(lat), 64'd34);
      check("busy_start_result", 64'(result), 64'd14);
      check("busy_start_wb_rd", 64'(wb_rd), 64'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_start_busy", 64'(busy), 64'd0);
      count_dones("busy_start", 40);

      // Asynchronous reset in the middle of a divide.
      issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9);
      repeat (5) @(negedge clk);
      #1 rstn = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_result", 64'(result), 64'd0);
      check("arst_wb_rd", 64'(wb_rd), 64'd0);
      check("arst_wb_en", 64'(wb_en), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      count_dones("arst", 40);

      for (int k = 0; k < 60; k++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         int          sel;
         f3  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'h0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 20));
         else if (sel == 3) b = -32'($urandom_range(1, 20));
         run_op($sformatf("rnd%0d_f%0d", k, f3), f3, a, b, 5'($urandom_range(0, 31)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
